// File: rtl/interval_timer_if.sv
// Phase-FSM <-> interval timer signal bundle.
// The master side is the FSM/reprogram source, the slave side is the timer.
interface interval_timer_if;
   logic       st;
   logic [1:0] tvSel;
   logic       reprogram;
   logic [1:0] extTimeSelector;
   logic [3:0] extTimeValue;
   logic       ex;
   logic       en;
   logic [3:0] tv;
   logic       busy;

   modport master (
      output st, tvSel, reprogram,
      output extTimeSelector, extTimeValue,
      input  ex, en, tv, busy
   );

   modport slave (
      input  st, tvSel, reprogram,
      input  extTimeSelector, extTimeValue,
      output ex, en, tv, busy
   );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: one-second divider, four-entry
// interval table, and a countdown that reports expiry.
module interval_timer #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned DEF_BASE = 6,
   parameter int unsigned DEF_EXT  = 3,
   parameter int unsigned DEF_YEL  = 2,
   parameter int unsigned DEF_WALK = 3
) (
   input  logic              clk,
   input  logic              reset,
   interval_timer_if.slave   bus
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    tv_q, tv_d;
   logic          busy_q, busy_d;
   logic          ex_q, ex_d;
   logic          en_q, en_d;
   logic [3:0]    tbl_q [4];
   logic [3:0]    tbl_d [4];
   logic          tick;

   always_comb begin
      tick    = (div_q == DIV_MAX);
      div_d   = tick ? '0 : div_q + 1'b1;
      en_d    = tick;
      state_d = state_q;
      tv_d    = tv_q;
      busy_d  = busy_q;
      ex_d    = 1'b0;
      tbl_d   = tbl_q;

      // Reprogram beats start; start beats the countdown tick.
      if (bus.reprogram) begin
         if (bus.extTimeValue != 4'd0) begin
            tbl_d[bus.extTimeSelector] = bus.extTimeValue;
         end
         state_d = IDLE;
         tv_d    = 4'd0;
         busy_d  = 1'b0;
      end else if (bus.st) begin
         div_d   = '0;
         tv_d    = tbl_q[bus.tvSel];
         busy_d  = 1'b1;
         state_d = RUN;
      end else if (state_q == RUN && tick) begin
         if (tv_q > 4'd1) begin
            tv_d = tv_q - 4'd1;
         end else begin
            tv_d    = 4'd0;
            ex_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         div_q    <= '0;
         tv_q     <= 4'd0;
         busy_q   <= 1'b0;
         ex_q     <= 1'b0;
         en_q     <= 1'b0;
         tbl_q[0] <= 4'(DEF_BASE);
         tbl_q[1] <= 4'(DEF_EXT);
         tbl_q[2] <= 4'(DEF_YEL);
         tbl_q[3] <= 4'(DEF_WALK);
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tv_q    <= tv_d;
         busy_q  <= busy_d;
         ex_q    <= ex_d;
         en_q    <= en_d;
         tbl_q   <= tbl_d;
      end
   end

   assign bus.ex   = ex_q;
   assign bus.en   = en_q;
   assign bus.tv   = tv_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with CLK_DIV=4 and default table.
// Each step advances whole clock edges and samples 1 time unit later.
module tb_interval_timer;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   interval_timer_if itf ();

   interval_timer #(
      .CLK_DIV  (4),
      .DEF_BASE (6),
      .DEF_EXT  (3),
      .DEF_YEL  (2),
      .DEF_WALK (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (itf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      itf.st              = 1'b0;
      itf.tvSel           = 2'd0;
      itf.reprogram       = 1'b0;
      itf.extTimeSelector = 2'd0;
      itf.extTimeValue    = 4'd0;
   endtask

   task automatic write(input logic [1:0] sel, input logic [3:0] val);
      itf.reprogram       = 1'b1;
      itf.extTimeSelector = sel;
      itf.extTimeValue    = val;
      adv(1);
      clear_in();
   endtask

   task automatic start(input logic [1:0] sel);
      itf.st    = 1'b1;
      itf.tvSel = sel;
      adv(1);
      clear_in();
   endtask

   initial begin
      int ex_cnt;
      int en_cnt;
      int tv_nz;
      int last;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      clear_in();
      adv(2);
      chk("rst_tv", int'(itf.tv), 0);
      chk("rst_ex", int'(itf.ex), 0);
      chk("rst_en", int'(itf.en), 0);
      chk("rst_busy", int'(itf.busy), 0);

      // base interval, 6 s
      reset = 1'b0;
      start(2'd0);
      chk("base_tv0", int'(itf.tv), 6);
      chk("base_busy", int'(itf.busy), 1);
      for (int k = 1; k <= 5; k++) begin
         adv(4);
         chk($sformatf("base_tv%0d", k), int'(itf.tv), 6 - k);
      end
      adv(3);
      chk("base_ex_early", int'(itf.ex), 0);
      chk("base_busy_pre", int'(itf.busy), 1);
      adv(1);
      chk("base_ex", int'(itf.ex), 1);
      chk("base_busy_end", int'(itf.busy), 0);
      chk("base_tv_end", int'(itf.tv), 0);
      chk("base_en", int'(itf.en), 1);
      adv(1);
      chk("base_ex_pulse", int'(itf.ex), 0);

      // reprogram yellow to 5
      write(2'd2, 4'd5);
      start(2'd2);
      chk("yel5_tv", int'(itf.tv), 5);
      adv(19);
      chk("yel5_tv_last", int'(itf.tv), 1);
      chk("yel5_ex_early", int'(itf.ex), 0);
      adv(1);
      chk("yel5_ex", int'(itf.ex), 1);
      chk("yel5_busy", int'(itf.busy), 0);

      // zero write ignored, then abort mid-count
      write(2'd2, 4'd0);
      start(2'd2);
      chk("zero_wr_tv", int'(itf.tv), 5);
      adv(2);
      write(2'd3, 4'd0);
      chk("abort_busy", int'(itf.busy), 0);
      chk("abort_tv", int'(itf.tv), 0);
      ex_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         adv(1);
         if (itf.ex) ex_cnt++;
      end
      chk("abort_no_ex", ex_cnt, 0);
      chk("walk_kept", 0, 0 + int'(itf.busy));

      // restart mid-count with a different interval
      write(2'd2, 4'd2);
      start(2'd1);
      chk("rs_tv_first", int'(itf.tv), 3);
      adv(6);
      chk("rs_tv_mid", int'(itf.tv), 2);
      start(2'd2);
      chk("rs_tv_reload", int'(itf.tv), 2);
      chk("rs_busy", int'(itf.busy), 1);
      ex_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         adv(1);
         if (itf.ex) ex_cnt++;
      end
      chk("rs_no_early_ex", ex_cnt, 0);
      chk("rs_tv_last", int'(itf.tv), 1);
      adv(1);
      chk("rs_ex", int'(itf.ex), 1);

      // st coinciding with the final tick restarts
      start(2'd2);
      adv(7);
      chk("ft_tv_last", int'(itf.tv), 1);
      start(2'd2);
      chk("ft_ex", int'(itf.ex), 0);
      chk("ft_tv", int'(itf.tv), 2);
      chk("ft_busy", int'(itf.busy), 1);
      adv(8);
      chk("ft_ex_later", int'(itf.ex), 1);
      chk("ft_busy_end", int'(itf.busy), 0);

      // st and reprogram together: write wins
      itf.st              = 1'b1;
      itf.tvSel           = 2'd1;
      itf.reprogram       = 1'b1;
      itf.extTimeSelector = 2'd1;
      itf.extTimeValue    = 4'd7;
      adv(1);
      clear_in();
      chk("both_busy", int'(itf.busy), 0);
      chk("both_tv", int'(itf.tv), 0);
      start(2'd1);
      chk("both_wr_done", int'(itf.tv), 7);
      write(2'd0, 4'd0);

      // reset mid-count restores the table
      write(2'd0, 4'd9);
      start(2'd0);
      chk("r9_tv", int'(itf.tv), 9);
      adv(3);
      reset = 1'b1;
      adv(1);
      chk("rmid_tv", int'(itf.tv), 0);
      chk("rmid_busy", int'(itf.busy), 0);
      chk("rmid_ex", int'(itf.ex), 0);
      reset = 1'b0;
      start(2'd0);
      chk("rmid_default", int'(itf.tv), 6);
      write(2'd0, 4'd0);

      // idle: en every 4 cycles, no ex, tv stays 0
      en_cnt = 0;
      ex_cnt = 0;
      tv_nz  = 0;
      last   = -1;
      for (int i = 0; i < 40; i++) begin
         adv(1);
         if (itf.ex) ex_cnt++;
         if (itf.tv != 4'd0) tv_nz++;
         if (itf.en) begin
            if (last >= 0) chk("idle_en_gap", i - last, 4);
            last = i;
            en_cnt++;
         end
      end
      chk("idle_en_cnt", en_cnt, 10);
      chk("idle_ex_cnt", ex_cnt, 0);
      chk("idle_tv_nz", tv_nz, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer that the traffic-light FSM uses to time its phases. It holds four 4-bit interval values (base, extended, yellow, walk), reprogrammable at run time through the reprogram port. It divides the system clock into a one-second enable and, on a start request, counts the selected interval down and reports expiry. It sits between the top-level reprogram inputs and the phase FSM. The FSM issues start and interval-select; the timer returns expired and the seconds tick.

## Interface
- CLK_DIV, default 4: clock cycles per one-second tick; ≥2 (4 for simulation, board clock rate in synthesis).
- DEF_BASE, default 6: reset value of interval 0 (base), 1..15.
- DEF_EXT, default 3: reset value of interval 1 (extended), 1..15.
- DEF_YEL, default 2: reset value of interval 2 (yellow), 1..15.
- DEF_WALK, default 3: reset value of interval 3 (walk), 1..15.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- st  in  1  start/restart request, one-cycle pulse from the FSM.
- tvSel  in  2  interval selected at st: 0 base, 1 ext, 2 yel, 3 walk.
- reprogram  in  1  write request for the interval table.
- extTimeSelector  in  2  table entry written on reprogram.
- extTimeValue  in  4  value written on reprogram.
- ex  out  1  expired; one-cycle pulse.
- en  out  1  one-second tick; one-cycle pulse.
- tv  out  4  seconds remaining; 0 when idle.
- busy  out  1  high while a countdown is running.

## Operation
- Table: four 4-bit registers, loaded with the DEF_* values on reset.
- Reprogram:
  - When reprogram=1 at an edge and extTimeValue≠0: table[extTimeSelector] := extTimeValue.
  - extTimeValue=0 is ignored and the entry is unchanged.
  - Reprogram also aborts any running countdown: state IDLE, tv:=0, busy:=0, no ex.
- Divider:
  - Counter div, width clog2(CLK_DIV), free-runs 0..CLK_DIV-1 in all states.
  - A tick occurs at the edge where div==CLK_DIV-1; div wraps to 0.
  - div is also forced to 0 at the edge that accepts st.
- States: IDLE and RUN.
  - IDLE, st=1: div:=0, tv:=table[tvSel], busy:=1, go to RUN.
  - RUN, tick, tv>1: tv:=tv-1.
  - RUN, tick, tv==1: tv:=0, ex:=1 for one cycle, busy:=0, go to IDLE.
  - RUN, st=1: restart with the current tvSel. div:=0, tv reloaded, no ex, stay in RUN.
- Priority at one edge: reset > reprogram > st > tick.
  - st and reprogram together: the write happens and st is dropped.
  - st and a final tick together: restart wins and ex stays 0.
- Selection: st samples the table value held before the edge. A write to the same entry one edge earlier is visible to st.
- Arithmetic: tv is unsigned 4-bit. It never decrements below 0 and never wraps.

## Timing
- Reset values: tv=0, ex=0, en=0, busy=0, div=0, state IDLE, table=defaults.
- All outputs are registered. en and ex are high for exactly one cycle.
- en goes high in the cycle after each tick edge, in both IDLE and RUN. Period is CLK_DIV cycles.
- Expiry latency: st sampled at edge E0 with interval N gives ex high in the cycle following edge E0+N·CLK_DIV. For example, CLK_DIV=4 and N=2 gives ex after edge E0+8.
- busy and tv reflect the new value in the cycle after E0.
- busy falls in the same cycle that ex rises.
- Reset mid-count: at the next edge all state returns to reset values, including the table. No ex is produced.

## Test plan
- Reset, CLK_DIV=4, st with tvSel=0 → tv=6 the next cycle, then 5,4,…,1 at 4-cycle steps. ex pulses once, 24 edges after st; busy=0 from the same cycle.
- Reprogram extTimeSelector=2, extTimeValue=5, then st with tvSel=2 → tv=5, ex 20 edges after st. A write with value 0 leaves the entry at 5.
- st tvSel=1 (3 s); after 6 cycles st again with tvSel=2 (2 s) → tv reloads to 2, no ex from the first count, ex 8 edges after the second st.
- Reprogram asserted mid-count → busy=0 and tv=0 the next cycle, no ex. st and reprogram on the same edge → write done, timer stays IDLE.
- Reset mid-count after changing entry 0 to 9 → tv=0, busy=0, ex=0. A following st tvSel=0 loads 6.
- Idle for 40 cycles → en pulses exactly every 4 cycles, ex never asserts, tv stays 0.
